// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit and imem.
//   imem_req    fetch -> mem : request valid
//   imem_addr   fetch -> mem : word address of request
//   imem_gnt    mem -> fetch : request accepted this cycle
//   imem_rvalid mem -> fetch : response valid
//   imem_rdata  mem -> fetch : response instruction word
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one request in flight to
// instruction memory, presents returned words with their PC to decode, holds a
// late response in a one-entry skid buffer, follows redirects and stops on HALT.
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   imem         instruction-memory bus (master side)
//   redirect     taken branch/jump, replaces fetch PC
//   redirect_pc  redirect target
//   stall        decode cannot accept the presented instruction
//   inst / pc    instruction to decode and its address
//   inst_valid   inst/pc hold a live instruction
//   halted       HALT delivered, fetch stopped
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | one cycle after reset before the first request
// S_REQ    | request fetch_pc (only while skid buffer is empty)
// S_WAIT   | request accepted, waiting for response (kill drops it)
// S_HALTED | HALT fetched; only redirect or reset leaves
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  input  logic         stall,
  output logic [15:0]  inst,
  output logic [15:0]  pc,
  output logic         inst_valid,
  output logic         halted
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALTED} state_t;

  state_t      state;
  logic [15:0] fetch_pc;
  logic        kill;
  logic        skid_valid;
  logic [15:0] skid_inst;
  logic [15:0] skid_pc;

  logic slot_free;
  logic resp;
  logic hs;

  // Request and address come straight from registers, so the address is
  // stable for as long as the request is waiting for a grant.
  assign imem.imem_req  = (state == S_REQ) && !skid_valid;
  assign imem.imem_addr = fetch_pc;

  assign slot_free = !inst_valid || !stall;
  assign resp      = (state == S_WAIT) && imem.imem_rvalid && !kill;
  assign hs        = imem.imem_req && imem.imem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      kill       <= 1'b0;
      inst       <= NOP_INST;
      pc         <= 16'h0000;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
      skid_valid <= 1'b0;
      skid_inst  <= NOP_INST;
      skid_pc    <= 16'h0000;
    end else if (redirect) begin
      fetch_pc   <= redirect_pc;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
      halted     <= 1'b0;
      // A request already accepted (or still pending) on the old path must
      // have its response swallowed before the new path is requested.
      if ((state == S_WAIT && !imem.imem_rvalid) || (state == S_REQ && hs)) begin
        kill  <= 1'b1;
        state <= S_WAIT;
      end else begin
        kill  <= 1'b0;
        state <= S_REQ;
      end
    end else begin
      // Output slot: skid first, then a same-cycle response. A full skid
      // blocks new requests, so skid and response never collide.
      if (slot_free) begin
        if (skid_valid) begin
          inst       <= skid_inst;
          pc         <= skid_pc;
          inst_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (resp) begin
          inst       <= imem.imem_rdata;
          pc         <= fetch_pc;
          inst_valid <= 1'b1;
        end else begin
          inst       <= NOP_INST;
          inst_valid <= 1'b0;
        end
      end else if (resp) begin
        skid_inst  <= imem.imem_rdata;
        skid_pc    <= fetch_pc;
        skid_valid <= 1'b1;
      end

      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (hs) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              fetch_pc <= fetch_pc + 16'd1;
              if (imem.imem_rdata[15:12] == HALT_OP) begin
                state  <= S_HALTED;
                halted <= 1'b1;
              end else begin
                state <= S_REQ;
              end
            end
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a random
// run, checked against a program-order model of the instruction stream.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic [15:0] inst;
  logic [15:0] pc;
  logic        inst_valid;
  logic        halted;

  fetch_unit_if mif ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (mif),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst        (inst),
    .pc          (pc),
    .inst_valid  (inst_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // memory model
  logic        pending;
  int          resp_cnt;
  logic [15:0] resp_addr;
  logic        gnt_rand;
  int          lat_fix;

  // program-order model
  logic [15:0] exp_pc;
  logic        halt_seen;
  int          consumed;

  // previous-cycle view
  logic        prev_valid, prev_stall, prev_redirect, prev_req, prev_gnt;
  logic [15:0] prev_inst, prev_pc, prev_addr;

  logic        hs_fired;
  logic [15:0] hs_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents: a bijective scramble of the address so every word is
  // distinct, with HALT opcodes only where placed on purpose.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == 16'h0000) return 16'h1250;
    if (a == 16'h0001) return 16'h7200;
    if (a == 16'h0003) return 16'hF000;
    w = 16'(a * 16'd40503) ^ 16'h5A3C;
    if (a[5:0] == 6'h2D)        w[15:12] = 4'hF;
    else if (w[15:12] == 4'hF)  w[15:12] = 4'h1;
    return w;
  endfunction

  task automatic reset_model();
    pending       = 1'b0;
    resp_cnt      = 0;
    exp_pc        = 16'h0000;
    halt_seen     = 1'b0;
    prev_valid    = 1'b0;
    prev_stall    = 1'b0;
    prev_redirect = 1'b0;
    prev_req      = 1'b0;
    prev_gnt      = 1'b0;
    prev_inst     = 16'h0000;
    prev_pc       = 16'h0000;
    prev_addr     = 16'h0000;
  endtask

  // Called at a negedge: drive inputs for the next edge, update the models,
  // cross the edge, then check the outputs at the following negedge.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc, input logic stale);
    logic pend0;
    logic g;
    pend0    = pending;
    hs_fired = 1'b0;
    mif.imem_rvalid = 1'b0;
    mif.imem_rdata  = 16'h0000;
    if (stale) begin
      mif.imem_rvalid = 1'b1;
      mif.imem_rdata  = 16'hDEAD;
    end else if (pending) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mif.imem_rvalid = 1'b1;
        mif.imem_rdata  = mem_word(resp_addr);
        pending         = 1'b0;
      end
    end
    g = gnt_rand ? ($urandom_range(0, 9) < 6) : 1'b1;
    mif.imem_gnt = g;
    if (mif.imem_req) chk("one_outstanding", pend0, 0);
    if (mif.imem_req && g) begin
      hs_fired  = 1'b1;
      hs_addr   = mif.imem_addr;
      pending   = 1'b1;
      resp_addr = mif.imem_addr;
      resp_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;

    if (inst_valid && !st && !rd) begin
      consumed++;
      chk("stream_pc", pc, exp_pc);
      chk("stream_inst", inst, mem_word(exp_pc));
      exp_pc = pc + 16'd1;
      if (inst[15:12] == 4'hF) halt_seen = 1'b1;
    end
    if (rd) begin
      exp_pc    = rpc;
      halt_seen = 1'b0;
    end

    prev_valid    = inst_valid;
    prev_inst     = inst;
    prev_pc       = pc;
    prev_stall    = st;
    prev_redirect = rd;
    prev_req      = mif.imem_req;
    prev_gnt      = g;
    prev_addr     = mif.imem_addr;

    @(posedge clk);
    @(negedge clk);

    if (!inst_valid) begin
      chk("nop_when_invalid", inst, 16'h0000);
      chk("pc_hold_invalid", pc, prev_pc);
    end
    if (halted) chk("halt_no_req", mif.imem_req, 0);
    if (prev_valid && prev_stall && !prev_redirect)
      chk("stall_hold", {inst_valid, inst, pc}, {1'b1, prev_inst, prev_pc});
    if (prev_req && !prev_gnt && !prev_redirect && mif.imem_req)
      chk("addr_stable", mif.imem_addr, prev_addr);
    if (prev_redirect) chk("redirect_flush", {inst_valid, halted}, 2'b00);
    if (halt_seen) chk("halt_state", {halted, inst_valid}, 2'b10);
    if (inst_valid) begin
      chk("inst_matches_mem", inst, mem_word(pc));
      if (inst[15:12] == 4'hF) chk("halt_flag", halted, 1);
    end
  endtask

  task automatic wait_hs(input string tag, input logic [15:0] exp_addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      if (hs_fired) found = 1'b1;
    end
    chk({tag, "_timeout"}, found, 1);
    if (found) chk(tag, hs_addr, exp_addr);
  endtask

  task automatic wait_valid(input string tag, input logic [15:0] exp_a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      if (inst_valid) found = 1'b1;
    end
    chk({tag, "_timeout"}, found, 1);
    if (found) chk(tag, {inst, pc}, {mem_word(exp_a), exp_a});
  endtask

  initial begin
    logic found;
    logic [15:0] rpc;
    rst             = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 16'h0000;
    mif.imem_gnt    = 1'b0;
    mif.imem_rvalid = 1'b0;
    mif.imem_rdata  = 16'h0000;
    gnt_rand        = 1'b0;
    lat_fix         = 1;
    consumed        = 0;
    hs_fired        = 1'b0;
    hs_addr         = 16'h0000;
    reset_model();
    repeat (3) @(negedge clk);
    chk("reset_values", {mif.imem_req, mif.imem_addr, inst_valid, inst, pc, halted}, 51'h0);
    rst = 1'b1;

    // straight-line fetch, then a stall that parks addr 1 in the skid
    wait_hs("first_addr", 16'h0000);
    wait_valid("first_inst", 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("second_addr", {hs_fired, hs_addr}, {1'b1, 16'h0001});
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("skid_blocks_req", mif.imem_req, 0);
    chk("stall_holds_first", {inst_valid, inst, pc}, {1'b1, 16'h1250, 16'h0000});
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("skid_drain", {inst_valid, inst, pc}, {1'b1, 16'h7200, 16'h0001});

    // HALT at pc 3
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      if (halted) found = 1'b1;
    end
    chk("halt_timeout", found, 1);
    chk("halt_presented", {inst_valid, inst, pc}, {1'b1, 16'hF000, 16'h0003});
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("halted_quiet", {halted, mif.imem_req}, 2'b10);
    end
    step(1'b0, 1'b1, 16'h0010, 1'b0);
    chk("halt_cleared", halted, 0);
    wait_valid("after_halt_redirect", 16'h0010);

    // redirect while waiting on addr 5: its response must be dropped
    step(1'b0, 1'b1, 16'h0005, 1'b0);
    lat_fix = 3;
    wait_hs("addr5", 16'h0005);
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    lat_fix = 1;
    wait_hs("redirect_addr", 16'h0040);
    wait_valid("redirect_inst", 16'h0040);

    // address wrap
    step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    wait_hs("addr_ffff", 16'hFFFF);
    wait_hs("addr_wrap", 16'h0000);

    // asynchronous reset in the middle of a wait
    lat_fix = 3;
    wait_hs("pre_reset_addr", 16'h0001);
    #2 rst = 1'b0;
    #1 chk("async_reset", {mif.imem_req, mif.imem_addr, inst_valid, inst, pc, halted}, 51'h0);
    reset_model();
    mif.imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    lat_fix = 1;
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    wait_hs("post_reset_addr", 16'h0000);
    wait_valid("post_reset_inst", 16'h0000);

    // random run
    gnt_rand = 1'b1;
    lat_fix  = 0;
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3, rpc, 1'b0);
    end
    chk("progress", consumed >= 150, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that feeds the decode stage.
- Owns the fetch PC and issues one word-addressed request at a time to instruction memory.
- Presents each returned 16-bit instruction with its PC to decode; a one-entry skid buffer absorbs a late response during a stall.
- Applies branch/jump redirects from execute and stops fetching after a HALT opcode (4'b1111).

Parameters:
RESET_PC, 16'h0000, fetch address after reset
NOP_INST, 16'h0000, value driven on inst whenever inst_valid=0 (opcode 4'b0000 = NOP)
HALT_OP, 4'hF, opcode in inst[15:12] that stops fetching

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
imem_req  output  1  request valid to instruction memory
imem_addr  output  16  word address of request
imem_gnt  input  1  memory accepts request this cycle (imem_req & imem_gnt = handshake)
imem_rvalid  input  1  response data valid; arrives >=1 cycle after handshake
imem_rdata  input  16  response instruction word
redirect  input  1  taken branch/jump; replaces fetch PC
redirect_pc  input  16  target address
stall  input  1  decode cannot accept the presented instruction this cycle
inst  output  16  instruction to decode
pc  output  16  address of inst
inst_valid  output  1  inst/pc are a live instruction
halted  output  1  HALT delivered; fetch stopped

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst=NOP_INST, pc=16'h0000, inst_valid=0, halted=0, skid empty, kill=0.
- States:
  - IDLE: go to REQ the next cycle.
  - REQ: imem_req=1, imem_addr=fetch_pc. Request is held only while the skid buffer is empty. On imem_gnt, go to WAIT.
  - WAIT: imem_req=0; wait for imem_rvalid.
  - HALTED: imem_req=0.
- At most one request is outstanding. imem_addr is stable while imem_req=1 and imem_gnt=0.
- Response in WAIT, kill=0:
  - If the output slot is free (inst_valid=0, or stall=0): load the word into the output register.
  - Otherwise: load it into the skid buffer.
  - fetch_pc <= fetch_pc+1 (wraps 16'hFFFF -> 16'h0000). Latency is handshake + memory latency + 1 register stage.
- HALT handling: if the word's [15:12] == HALT_OP, go to HALTED and set halted=1 in the same edge. The HALT word itself is still presented to decode. Otherwise return to REQ.
- Response in WAIT, kill=1: discard the word, clear kill, go to REQ.
- Output register:
  - Advances when inst_valid=0 or stall=0.
  - Loads from the skid buffer first, else from a same-cycle response, else becomes inst_valid=0.
  - While inst_valid=0, inst=NOP_INST and pc holds its last value.
  - While inst_valid=1 and stall=1, inst and pc are held unchanged.
- Redirect (highest priority, beats stall and rvalid), on the clock edge:
  - fetch_pc <= redirect_pc; output slot and skid flushed (inst_valid=0 next cycle).
  - From WAIT with no same-cycle rvalid, or from REQ with same-cycle imem_gnt: set kill=1, go to WAIT.
  - From WAIT with same-cycle rvalid: drop the word, go to REQ with kill=0.
  - From IDLE, REQ without gnt, or HALTED: go to REQ. halted clears, since a HALT on the wrong path is cancelled.
- HALTED is left only by redirect or reset.
- Reset mid-transaction: all state is cleared. A memory response arriving after reset release while in IDLE/REQ with no outstanding request is ignored.

Test Plan:
- Reset release, imem returns 16'h1250 (ADD) at addr 0 and 16'h7200 at addr 1, 1-cycle latency, stall=0 -> imem_addr 0 then 1; inst 16'h1250/pc 0, then 16'h7200/pc 1, inst_valid=1 each cycle after the data arrives.
- stall=1 for 3 cycles while inst 16'h1250 is presented, response for addr 1 arrives during the stall -> inst/pc held; word captured in skid; no new imem_req until the skid drains; 16'h7200/pc 1 presented the cycle after stall=0.
- redirect=1, redirect_pc=16'h0040 while WAIT on addr 5 -> the addr-5 response is discarded (never on inst); next imem_addr=16'h0040; inst_valid=0 until the 16'h0040 word returns.
- Memory returns 16'hF000 at pc 3 -> inst=16'hF000/pc 3 presented; halted=1; imem_req stays 0 for 20 cycles; a later redirect to 16'h0010 clears halted and fetches 16'h0010.
- fetch_pc=16'hFFFF returns a non-HALT word -> next imem_addr=16'h0000.
- rst driven low asynchronously mid-WAIT -> outputs go to reset values immediately; after release, first imem_addr=RESET_PC; a stale rvalid pulse is ignored.
